// File: rtl/early_dequeue_n_pkg.sv
// Shared configuration, buffer entry type and modular due-time compare for the dequeue slice.
// Optional statistics outputs are enabled by defining EARLY_DEQUEUE_STATS_EN.
package early_dequeue_n_pkg;

    localparam int unsigned ED_N      = 4;
    localparam int unsigned ED_WIDTH  = 3;
    localparam int unsigned ED_DWIDTH = 32;
    localparam int unsigned ED_PORT_W = $clog2(ED_N);
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ED_DWIDTH-1:0] data;
        logic [ED_WIDTH-1:0]  ts;
        logic [ED_PORT_W-1:0] port;
    } entry_t;

    // True when ts is at or before now, within half the wrap-around time range.
    function automatic logic ts_due(input logic [ED_WIDTH-1:0] ts, input logic [ED_WIDTH-1:0] now);
        logic [ED_WIDTH-1:0] diff;
        diff = now - ts;
        return ~diff[ED_WIDTH-1];
    endfunction

endpackage

// File: rtl/early_dequeue_n_if.sv
// Queue-head inputs and buffered valid/ready output of the early dequeue stage.
interface early_dequeue_n_if;
    import early_dequeue_n_pkg::*;

    logic [ED_N*ED_DWIDTH-1:0] in_data;
    logic [ED_N*ED_WIDTH-1:0]  in_ts;
    logic [ED_N-1:0]           in_valid;
    logic [ED_N-1:0]           in_pop;
    logic [ED_DWIDTH-1:0]      out_data;
    logic [ED_WIDTH-1:0]       out_ts;
    logic [ED_PORT_W-1:0]      out_port;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        input  in_data, in_ts, in_valid, out_ready,
        output in_pop, out_data, out_ts, out_port, out_valid
    );

    modport slave (
        output in_data, in_ts, in_valid, out_ready,
        input  in_pop, out_data, out_ts, out_port, out_valid
    );

endinterface

// File: rtl/early_dequeue_n_buf.sv
// Two-entry valid/ready FIFO; the head register drives the outputs directly.
module early_dequeue_n_buf
    import early_dequeue_n_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  entry_t din,
    input  logic   ready,
    output entry_t head,
    output logic   valid,
    output logic   full
);

    entry_t           tail;
    logic [CNT_W-1:0] count;
    logic             pop_c;

    assign pop_c = valid & ready;
    assign valid = (count != '0);
    assign full  = (count == CNT_W'(BUF_DEPTH));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({push, pop_c})
                2'b10: begin
                    if (count == '0) head <= din;
                    else             tail <= din;
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - CNT_W'(1);
                end
                2'b11: begin
                    // Count holds: new entry lands behind whatever remains.
                    if (count == CNT_W'(BUF_DEPTH)) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/select_early_n.sv
// Picks the valid queue head with the smallest timestamp; lowest index wins ties.
module select_early_n #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 3,
    localparam int unsigned SW   = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] ts_in,
    input  logic [N-1:0]       valid,
    output logic [WIDTH-1:0]   tmin,
    output logic [SW-1:0]      sel,
    output logic               sel_valid
);

    always_comb begin
        tmin      = '0;
        sel       = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (!sel_valid || (ts_in[i*WIDTH +: WIDTH] < tmin))) begin
                tmin      = ts_in[i*WIDTH +: WIDTH];
                sel       = SW'(i);
                sel_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/early_dequeue_n.sv
// Pops the earliest due queue head into a 2-entry output buffer.
// Define EARLY_DEQUEUE_STATS_EN to add saturating pop/stall counters.
module early_dequeue_n
    import early_dequeue_n_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [ED_WIDTH-1:0] sim_time,
    early_dequeue_n_if.master   bus
`ifdef EARLY_DEQUEUE_STATS_EN
    ,
    output logic [31:0]         stat_pops,
    output logic [31:0]         stat_stalls
`endif
);

    logic [ED_WIDTH-1:0]  tmin;
    logic [ED_PORT_W-1:0] sel;
    logic                 sel_valid;
    logic                 due_c;
    logic                 space_c;
    logic                 fire_c;
    logic                 full;
    logic                 head_valid;
    logic [ED_N-1:0]      pop_c;
    entry_t               din;
    entry_t               head;
    logic [ED_DWIDTH-1:0] data_arr [ED_N];

    select_early_n #(.N(ED_N), .WIDTH(ED_WIDTH)) u_sel (
        .ts_in     (bus.in_ts),
        .valid     (bus.in_valid),
        .tmin      (tmin),
        .sel       (sel),
        .sel_valid (sel_valid)
    );

    for (genvar i = 0; i < ED_N; i++) begin : g_unpack
        assign data_arr[i] = bus.in_data[i*ED_DWIDTH +: ED_DWIDTH];
    end

    assign due_c   = ts_due(tmin, sim_time);
    assign space_c = ~full | bus.out_ready;
    assign fire_c  = enable & sel_valid & due_c & space_c & ~reset;

    always_comb begin
        pop_c = '0;
        if (fire_c) pop_c[sel] = 1'b1;
    end

    assign din = '{data: data_arr[sel], ts: tmin, port: sel};

    early_dequeue_n_buf u_buf (
        .clock (clock),
        .reset (reset),
        .push  (fire_c),
        .din   (din),
        .ready (bus.out_ready),
        .head  (head),
        .valid (head_valid),
        .full  (full)
    );

    assign bus.in_pop    = pop_c;
    assign bus.out_data  = head.data;
    assign bus.out_ts    = head.ts;
    assign bus.out_port  = head.port;
    assign bus.out_valid = head_valid;

`ifdef EARLY_DEQUEUE_STATS_EN
    logic stall_c;
    assign stall_c = enable & sel_valid & due_c & ~space_c;

    // Saturating event counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_pops   <= '0;
            stat_stalls <= '0;
        end else begin
            if (fire_c && (stat_pops != '1))    stat_pops   <= stat_pops + 32'd1;
            if (stall_c && (stat_stalls != '1)) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_early_dequeue_n.sv
// Directed table-driven bench for early_dequeue_n (N=4, WIDTH=3, DWIDTH=32).
module tb_early_dequeue_n;
    import early_dequeue_n_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] sim_time;
    int         total = 0;
    int         bad   = 0;

`ifdef EARLY_DEQUEUE_STATS_EN
    logic [31:0] stat_pops;
    logic [31:0] stat_stalls;
`endif

    always #5 clock = ~clock;

    early_dequeue_n_if bus();

    early_dequeue_n dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sim_time (sim_time),
        .bus      (bus)
`ifdef EARLY_DEQUEUE_STATS_EN
        ,
        .stat_pops   (stat_pops),
        .stat_stalls (stat_stalls)
`endif
    );

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] ts;
        logic [2:0]  now;
        logic        en;
        logic [3:0]  pop;
        logic [1:0]  port;
        logic [2:0]  ots;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0110, {3'd0, 3'd3, 3'd5, 3'd0}, 3'd3, 1'b1, 4'b0100, 2'd2, 3'd3};
        vecs[1]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 3'd4, 1'b1, 4'b0000, 2'd0, 3'd0};
        vecs[2]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 3'd6, 1'b1, 4'b0001, 2'd0, 3'd6};
        vecs[3]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd7}, 3'd1, 1'b1, 4'b0001, 2'd0, 3'd7};
        vecs[4]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, 3'd7, 1'b1, 4'b0000, 2'd0, 3'd0};
        vecs[5]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 3'd1, 1'b0, 4'b0000, 2'd0, 3'd0};
        vecs[6]  = '{4'b1111, {3'd1, 3'd7, 3'd2, 3'd6}, 3'd3, 1'b1, 4'b1000, 2'd3, 3'd1};
        vecs[7]  = '{4'b0000, {3'd1, 3'd1, 3'd1, 3'd1}, 3'd7, 1'b1, 4'b0000, 2'd0, 3'd0};
        vecs[8]  = '{4'b1001, {3'd4, 3'd0, 3'd0, 3'd0}, 3'd0, 1'b1, 4'b0001, 2'd0, 3'd0};
        vecs[9]  = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd4, 1'b1, 4'b0000, 2'd0, 3'd0};
        vecs[10] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd0}, 3'd3, 1'b1, 4'b0001, 2'd0, 3'd0};
        vecs[11] = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 3'd5, 1'b1, 4'b0100, 2'd2, 3'd5};

        reset         = 1'b1;
        enable        = 1'b0;
        sim_time      = '0;
        bus.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        bus.in_ts     = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;

        @(negedge clock);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_ts", 32'(bus.out_ts), 32'd0);
        chk("rst_out_port", 32'(bus.out_port), 32'd0);
        chk("rst_in_pop", 32'(bus.in_pop), 32'd0);
        reset = 1'b0;
        step();

        // Single-shot vectors: apply, check pop, check buffered head, drain.
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = vecs[i].valid;
            bus.in_ts    = vecs[i].ts;
            sim_time     = vecs[i].now;
            enable       = vecs[i].en;
            #1;
            chk($sformatf("v%0d_in_pop", i), 32'(bus.in_pop), 32'(vecs[i].pop));
            step();
            bus.in_valid = '0;
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].pop != 4'b0000));
            if (vecs[i].pop != 4'b0000) begin
                chk($sformatf("v%0d_out_port", i), 32'(bus.out_port), 32'(vecs[i].port));
                chk($sformatf("v%0d_out_ts", i), 32'(bus.out_ts), 32'(vecs[i].ots));
                chk($sformatf("v%0d_out_data", i), bus.out_data, 32'hA0 + 32'(vecs[i].port));
            end
            step();
            chk($sformatf("v%0d_drained", i), 32'(bus.out_valid), 32'd0);
        end

        // Reset with a full buffer flushes it and blocks in_pop immediately.
        enable        = 1'b1;
        sim_time      = 3'd2;
        bus.in_ts     = {3'd0, 3'd0, 3'd0, 3'd2};
        bus.in_valid  = 4'b0001;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_pop", 32'(bus.in_pop), 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("full_ready_in_pop", 32'(bus.in_pop), 32'b0001);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("async_rst_in_pop", 32'(bus.in_pop), 32'd0);
        bus.in_valid = '0;
        @(negedge clock);
        reset = 1'b0;
        step();
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: three due heads, consumer stalled for ten cycles.
        bus.out_ready = 1'b0;
        sim_time      = 3'd3;
        bus.in_ts     = {3'd0, 3'd3, 3'd2, 3'd1};
        bus.in_valid  = 4'b0111;
        #1;
        chk("bp_pop0", 32'(bus.in_pop), 32'b0001);
        step();
        bus.in_valid = 4'b0110;
        #1;
        chk("bp_pop1", 32'(bus.in_pop), 32'b0010);
        step();
        bus.in_valid = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("bp_stall%0d_in_pop", c), 32'(bus.in_pop), 32'd0);
            step();
        end
        chk("bp_head_port", 32'(bus.out_port), 32'd0);
        chk("bp_head_ts", 32'(bus.out_ts), 32'd1);
`ifdef EARLY_DEQUEUE_STATS_EN
        chk("stat_pops", stat_pops, 32'd2);
        chk("stat_stalls", stat_stalls, 32'd8);
`endif
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_pop", 32'(bus.in_pop), 32'b0100);
        step();
        bus.in_valid = '0;
        chk("bp_after_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_after_port", 32'(bus.out_port), 32'd1);
        step();
        chk("bp_last_port", 32'(bus.out_port), 32'd2);
        chk("bp_last_ts", 32'(bus.out_ts), 32'd3);
        chk("bp_last_data", bus.out_data, 32'hA2);
        step();
        chk("bp_empty", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
